// File: rtl/pipe1_fetch_decode.sv
// rtl/pipe1_fetch_decode.sv - instruction fetch/decode stage with valid/ready issue and optional RAW interlock
// Optional feature: define FETCH_HAZARD_INTERLOCK_EN to enable the RAW hazard interlock and its issue history.
module pipe1_fetch_decode #(
    parameter int         IMEM_DEPTH = 256,
`ifdef FETCH_HAZARD_INTERLOCK_EN
    parameter int         HAZ_DEPTH  = 2,
`endif
    parameter logic [3:0] HALT_FUNC  = 4'hF,
    localparam int        PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_waddr,
    input  logic [23:0]     imem_wdata,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic [3:0]      func,
    output logic [7:0]      addr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [23:0]     r_imem [IMEM_DEPTH];
    logic [PC_W-1:0] r_pc;
    logic            r_out_valid;
    logic [3:0]      r_func;
    logic [3:0]      r_rd;
    logic [3:0]      r_rs1;
    logic [3:0]      r_rs2;
    logic [7:0]      r_addr;

    logic [23:0]     w_word;
    logic            w_slot_free;
    logic            w_is_halt;
    logic            w_hazard;
    logic            w_issue;
    logic            w_start_ok;

    assign w_word      = r_imem[r_pc];
    assign w_start_ok  = start && (r_state != S_RUN);
    assign w_slot_free = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_is_halt   = (w_word[23:20] == HALT_FUNC);
    assign w_issue     = w_slot_free && !w_is_halt && !w_hazard;

    // Program loading is only allowed while the fetch side is stopped.
    always_ff @(posedge clk) begin
        if (imem_we && (r_state != S_RUN)) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_slot_free && w_is_halt) w_state_nxt = S_HALT;
            S_HALT:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef FETCH_HAZARD_INTERLOCK_EN
    logic [HAZ_DEPTH-1:0]      r_hist_v;
    logic [HAZ_DEPTH-1:0][3:0] r_hist_rd;

    // Downstream writes back two slots after read with no forwarding, so stall on any recent producer.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (r_hist_v[i] && ((r_hist_rd[i] == w_word[15:12]) || (r_hist_rd[i] == w_word[11:8]))) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist_v  <= '0;
            r_hist_rd <= '0;
        end else if (w_start_ok) begin
            r_hist_v  <= '0;
            r_hist_rd <= '0;
        end else if (w_slot_free) begin
            r_hist_v[0]  <= w_issue;
            r_hist_rd[0] <= w_word[19:16];
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                r_hist_v[i]  <= r_hist_v[i-1];
                r_hist_rd[i] <= r_hist_rd[i-1];
            end
        end
    end
`else
    assign w_hazard = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_func      <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_addr      <= '0;
        end else if (w_start_ok) begin
            r_pc        <= '0;
            r_out_valid <= 1'b0;
        end else if (w_slot_free) begin
            r_out_valid <= w_issue;
            if (w_issue) begin
                r_func <= w_word[23:20];
                r_rd   <= w_word[19:16];
                r_rs1  <= w_word[15:12];
                r_rs2  <= w_word[11:8];
                r_addr <= w_word[7:0];
                r_pc   <= r_pc + PC_W'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign func      = r_func;
    assign rd        = r_rd;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign addr      = r_addr;
    assign pc        = r_pc;
    assign busy      = (r_state == S_RUN);
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_pipe1_fetch_decode.sv
// tb/tb_pipe1_fetch_decode.sv - self-checking bench for pipe1_fetch_decode
module tb_pipe1_fetch_decode;

    localparam int          HAZ_DEPTH = 2;
    localparam logic [23:0] NOP_W     = {4'h0, 4'h0, 4'h1, 4'h1, 8'h00};
    localparam logic [23:0] HALT_W    = {4'hF, 20'h0};

    typedef struct {
        logic       ready;
        logic       v;
        logic [3:0] func;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] addr;
        logic [7:0] pc;
        logic       busy;
        logic       halted;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [23:0] imem_wdata;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    pipe1_fetch_decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .func       (func),
        .addr       (addr),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program image, run state and a queue of recently issued rd values (-1 = empty slot).
    logic [23:0] m_mem [256];
    int          m_state;
    logic [7:0]  m_pc;
    logic        m_valid;
    logic [23:0] m_word;
    int          m_hist [$];
    vec_t        tbl [$];
    int          vectors;
    int          miscompares;

    task automatic model_reset();
        m_state = 0;
        m_pc    = 8'd0;
        m_valid = 1'b0;
        m_word  = 24'h0;
        m_hist.delete();
    endtask

    task automatic model_step();
        logic [23:0] w;
        bit          haz;
        if (imem_we && m_state != 1) m_mem[imem_waddr] = imem_wdata;
        if (start && m_state != 1) begin
            m_state = 1;
            m_pc    = 8'd0;
            m_valid = 1'b0;
            m_hist.delete();
        end else if (m_state == 1 && (!m_valid || out_ready)) begin
            w   = m_mem[m_pc];
            haz = 1'b0;
`ifdef FETCH_HAZARD_INTERLOCK_EN
            foreach (m_hist[i])
                if (m_hist[i] >= 0 && (m_hist[i] == int'(w[15:12]) || m_hist[i] == int'(w[11:8]))) haz = 1'b1;
`endif
            if (w[23:20] == 4'hF) begin
                m_valid = 1'b0;
                m_state = 2;
                m_hist.push_front(-1);
            end else if (haz) begin
                m_valid = 1'b0;
                m_hist.push_front(-1);
            end else begin
                m_valid = 1'b1;
                m_word  = w;
                m_pc    = m_pc + 8'd1;
                m_hist.push_front(int'(w[19:16]));
            end
            if (m_hist.size() > HAZ_DEPTH) void'(m_hist.pop_back());
        end
    endtask

    task automatic check_model(input string tag);
        vectors++;
        if (out_valid !== m_valid || pc !== m_pc || busy !== (m_state == 1) || halted !== (m_state == 2) ||
            {func, rd, rs1, rs2, addr} !== m_word) begin
            miscompares++;
            $display("FAIL %s t=%0t: got v=%0b pc=%0d busy=%0b halt=%0b word=%h, want v=%0b pc=%0d busy=%0b halt=%0b word=%h",
                     tag, $time, out_valid, pc, busy, halted, {func, rd, rs1, rs2, addr},
                     m_valid, m_pc, (m_state == 1), (m_state == 2), m_word);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        vectors++;
        if (out_valid !== e.v || pc !== e.pc || busy !== e.busy || halted !== e.halted ||
            {func, rd, rs1, rs2, addr} !== {e.func, e.rd, e.rs1, e.rs2, e.addr}) begin
            miscompares++;
            $display("FAIL %s t=%0t: got v=%0b pc=%0d busy=%0b halt=%0b word=%h, want v=%0b pc=%0d busy=%0b halt=%0b word=%h",
                     tag, $time, out_valid, pc, busy, halted, {func, rd, rs1, rs2, addr},
                     e.v, e.pc, e.busy, e.halted, {e.func, e.rd, e.rs1, e.rs2, e.addr});
        end
    endtask

    function automatic vec_t mk(logic rdy, logic v, logic [23:0] w, logic [7:0] p, logic b, logic h);
        vec_t r;
        r.ready = rdy; r.v = v;
        r.func = w[23:20]; r.rd = w[19:16]; r.rs1 = w[15:12]; r.rs2 = w[11:8]; r.addr = w[7:0];
        r.pc = p; r.busy = b; r.halted = h;
        return r;
    endfunction

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        start   = 1'b0;
        imem_we = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [23:0] w);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = w;
        tick("load");
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            out_ready = tbl[i].ready;
            tick(tag);
            check_vec(tag, tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        logic [23:0] w0, w1, w2, wa, wb, wc, wy;
        bit          done;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; imem_waddr = 8'h0; imem_wdata = 24'h0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_model("reset");
        check_vec("reset_zero", mk(1, 0, 24'h0, 8'd0, 0, 0));
        for (int a = 0; a < 256; a++) load(8'(a), NOP_W);

        // Independent stream then halt at 2.
        w0 = {4'h0, 4'd10, 4'd3, 4'd5, 8'd125};
        w1 = {4'h2, 4'd12, 4'd3, 4'd8, 8'd126};
        load(8'd0, w0); load(8'd1, w1); load(8'd2, HALT_W);
        start = 1'b1; tick("start_indep");
        tbl.push_back(mk(1, 1, w0, 8'd1, 1, 0));
        tbl.push_back(mk(1, 1, w1, 8'd2, 1, 0));
        tbl.push_back(mk(1, 0, w1, 8'd2, 0, 1));
        run_table("indep");

        // Dependent instruction directly behind its producer.
        w0 = {4'h0, 4'd10, 4'd3, 4'd5, 8'h10};
        w1 = {4'h1, 4'd11, 4'd10, 4'd4, 8'h11};
        load(8'd0, w0); load(8'd1, w1); load(8'd2, HALT_W);
        start = 1'b1; tick("start_raw");
        tbl.push_back(mk(1, 1, w0, 8'd1, 1, 0));
`ifdef FETCH_HAZARD_INTERLOCK_EN
        tbl.push_back(mk(1, 0, w0, 8'd1, 1, 0));
        tbl.push_back(mk(1, 0, w0, 8'd1, 1, 0));
`endif
        tbl.push_back(mk(1, 1, w1, 8'd2, 1, 0));
        tbl.push_back(mk(1, 0, w1, 8'd2, 0, 1));
        run_table("raw");

        // Backpressure for three cycles.
        w0 = {4'h0, 4'd1, 4'd2, 4'd3, 8'h20};
        w1 = {4'h0, 4'd4, 4'd5, 4'd6, 8'h21};
        w2 = {4'h0, 4'd7, 4'd8, 4'd9, 8'h22};
        load(8'd0, w0); load(8'd1, w1); load(8'd2, w2); load(8'd3, HALT_W);
        start = 1'b1; tick("start_bp");
        tbl.push_back(mk(1, 1, w0, 8'd1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, w0, 8'd1, 1, 0));
        tbl.push_back(mk(1, 1, w1, 8'd2, 1, 0));
        tbl.push_back(mk(1, 1, w2, 8'd3, 1, 0));
        tbl.push_back(mk(1, 0, w2, 8'd3, 0, 1));
        run_table("backpressure");

        // Restart with a same-cycle rewrite of word 0; a write during RUN must not land.
        load(8'd1, HALT_W);
        wy = {4'h3, 4'd13, 4'd6, 4'd7, 8'h33};
        imem_we = 1'b1; imem_waddr = 8'd0; imem_wdata = wy; start = 1'b1; out_ready = 1'b1;
        tick("restart");
        imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = NOP_W;
        tick("we_in_run");
        check_vec("restart_new_word", mk(1, 1, wy, 8'd1, 1, 0));
        tick("we_in_run_halt");
        check_vec("we_in_run_ignored", mk(1, 0, wy, 8'd1, 0, 1));

        // Walk through nops to the PC wrap.
        wa = {4'hE, 4'd3, 4'd11, 4'd13, 8'hA0};
        wb = {4'h4, 4'd5, 4'd6, 4'd7, 8'hB4};
        wc = {4'hC, 4'd8, 4'd9, 4'd10, 8'hC5};
        load(8'd1, NOP_W); load(8'd2, NOP_W); load(8'd3, NOP_W);
        load(8'd0, wa); load(8'd254, wb); load(8'd255, wc);
        start = 1'b1; tick("start_wrap");
        for (int k = 1; k <= 254; k++) tick("walk");
        tick("wrap"); check_vec("wrap_254", mk(1, 1, wb, 8'd255, 1, 0));
        tick("wrap"); check_vec("wrap_255", mk(1, 1, wc, 8'd0, 1, 0));
        tick("wrap"); check_vec("wrap_0", mk(1, 1, wa, 8'd1, 1, 0));

        // Asynchronous reset in the middle of a cycle while running.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        check_vec("async_rst_zero", mk(1, 0, 24'h0, 8'd0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick("post_rst");
        check_vec("post_rst_idle", mk(1, 0, 24'h0, 8'd0, 0, 0));
        tick("post_rst");

        // Randomized programs with dense register reuse, random backpressure and stray start/write pulses.
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 48; a++)
                load(8'(a), {4'($urandom_range(0, 14)), 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)),
                             4'($urandom_range(1, 4)), 8'($urandom)});
            load(8'd48, HALT_W);
            start = 1'b1; tick("rand_start");
            done = 1'b0;
            for (int c = 0; c < 800 && !done; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) start = 1'b1;
                if ($urandom_range(0, 9) == 0) begin
                    imem_we    = 1'b1;
                    imem_waddr = 8'($urandom_range(0, 63));
                    imem_wdata = 24'($urandom);
                end
                tick("rand");
                if (m_state == 2) done = 1'b1;
            end
            vectors++;
            if (!done) begin
                miscompares++;
                $display("FAIL rand_timeout: iteration %0d got no halt in 800 cycles, want halt", it);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by t=%0t, want completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/pipe1_fetch_decode.md
Name: pipe1_fetch_decode

Overview:
- Instruction fetch/decode stage directly upstream of the 4-stage register-read/ALU/writeback/store pipeline.
- Holds a 256-entry instruction memory and a program counter.
- Decodes each instruction into the rs1/rs2/rd/func/addr fields the pipeline consumes, with a valid/ready handshake.
- Interlocks on read-after-write hazards, because the downstream pipeline writes its register bank two issue slots after read and has no forwarding.

Parameters:
- IMEM_DEPTH, 256: instruction words; the PC is log2(IMEM_DEPTH) bits and wraps.
- HAZ_DEPTH, 2: number of previously issued slots checked for RAW hazards (1..4).
- HALT_FUNC, 4'hF: func code that stops fetch and is never issued.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALT.
- imem_we  in  1  instruction memory write enable.
- imem_waddr  in  8  instruction memory write address.
- imem_wdata  in  24  instruction word: [23:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr.
- out_ready  in  1  downstream accepts the current slot.
- out_valid  out  1  rs1/rs2/rd/func/addr hold an issued instruction.
- rs1, rs2, rd, func  out  4 each  decoded fields.
- addr  out  8  decoded store address.
- pc  out  8  address of the next instruction to fetch.
- busy  out  1  high in RUN.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0.
  - out_valid, all field outputs, busy and halted = 0.
  - Hazard history cleared.
  - imem contents are not reset.
- States IDLE, RUN, HALT:
  - IDLE --start--> RUN.
  - RUN --fetch of HALT_FUNC--> HALT.
  - HALT --start--> RUN with pc=0 and history cleared.
  - start in RUN is ignored.
- imem writes:
  - Effective only in IDLE or HALT; ignored in RUN.
  - A write and a start in the same cycle: the write lands and start is honoured.
- Slot advance: in RUN a slot is free when !out_valid || out_ready.
  - If out_valid && !out_ready, every output, pc and the history hold unchanged.
- On each free slot the block fetches imem[pc] combinationally, then applies the first matching rule:
  - func==HALT_FUNC: out_valid<=0, pc holds, go to HALT. The halt word is not issued.
  - Hazard (the rs1 or rs2 of the fetched word equals the rd of any valid history entry): bubble. out_valid<=0, pc holds, the fields keep their old values.
  - Otherwise issue: fields registered, out_valid<=1, pc<=pc+1 (255 wraps to 0).
- Hazard history: a HAZ_DEPTH-deep shift register of {valid, rd}.
  - Shifts on every free slot.
  - The new entry is {1, rd} on issue, and {0, x} on a bubble or halt.
- Latency: the first issue is visible one cycle after the start edge. Independent instructions issue one per cycle.
- With HAZ_DEPTH=2, a dependent instruction immediately after its producer gets exactly 2 bubbles. If it is two slots behind the producer, it gets 1 bubble.
- func 12..14 are issued unchanged and are recorded in the history.
- Reset mid-RUN aborts immediately; there is no partial output.

Optional Feature:
- Macro FETCH_HAZARD_INTERLOCK_EN.
- Defined: RAW interlock as above.
- Not defined: no hazard comparison, no bubbles, and the history is not built. Every non-halt fetch on a free slot issues, giving strict one-per-cycle issue; software must insert nops.

Test Plan:
- Reset: assert rst_n=0 mid-run -> out_valid=0, pc=0, busy=0, halted=0 asynchronously. Fields stay 0 after release until start.
- Independent stream: load {func0,rd10,rs3,rs5,addr125}, {2,12,3,8,126}, then HALT at 2; pulse start with out_ready=1 -> valid on 2 consecutive cycles with exact fields, then halted=1, pc=2.
- RAW interlock: word0 rd=10, word1 rs1=10 -> 2 cycles with out_valid=0 between the issues. With the macro undefined -> 0 bubbles.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> fields and pc stable, history not shifted. The next instruction issues the cycle after ready returns.
- Wrap: jump to pc 254 via imem of nops; words at 254, 255, 0 issue in order -> pc reads 255, 0, 1.
- Restart: start in HALT after rewriting imem[0] -> execution from pc 0 with the new word. imem_we in RUN -> memory unchanged.
